// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the frame-buffer capture engine and its raster
// counter: FSM state type, screen geometry and pixel/coordinate widths.
// No ports (package).
// ---------------------------------------------------------------------------
package capture_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIXEL_W  = 16;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STORE,
        DONE
    } capture_state_t;

    // Limit an exclusive end coordinate to the visible screen extent.
    function automatic logic [COORD_W-1:0] clampEnd(input logic [COORD_W-1:0] endVal,
                                                    input int limit);
        clampEnd = (int'(endVal) > limit) ? COORD_W'(limit) : endVal;
    endfunction

endpackage

// File: rtl/capture_engine_if.sv
// ---------------------------------------------------------------------------
// capture_engine_if
// Bundles the two buses the capture engine masters:
//   fetch side : fetchX/fetchY/fetchReq out, fetchValid/fetchData back in
//                (SRAM controller read port)
//   dest side  : destAddr/destData/destWrite out (on-chip RAM write port)
// Modports: master = capture engine, slave = SRAM controller + dest RAM.
// ---------------------------------------------------------------------------
interface capture_engine_if
    import capture_pkg::*;
#(
    parameter int DestAddrWidth = 14
);

    logic [COORD_W-1:0]       fetchX;
    logic [COORD_W-1:0]       fetchY;
    logic                     fetchReq;
    logic                     fetchValid;
    logic [PIXEL_W-1:0]       fetchData;
    logic [DestAddrWidth-1:0] destAddr;
    logic [PIXEL_W-1:0]       destData;
    logic                     destWrite;

    modport master (
        output fetchX, fetchY, fetchReq, destAddr, destData, destWrite,
        input  fetchValid, fetchData
    );

    modport slave (
        input  fetchX, fetchY, fetchReq, destAddr, destData, destWrite,
        output fetchValid, fetchData
    );

endinterface

// File: rtl/capture_raster_counter.sv
// ---------------------------------------------------------------------------
// capture_raster_counter
// Raster-order x/y walker over a rectangle [xStart,xEnd) x [yStart,yEnd).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_load            : capture start/end values and move to (xStart,yStart)
//   i_xStart..i_yEnd  : rectangle bounds (ends exclusive, must be non-empty
//                       when loaded)
//   i_step            : advance one pixel in raster order
//   o_x, o_y          : current coordinate (registered)
//   o_last            : current coordinate is the final pixel of the rectangle
// ---------------------------------------------------------------------------
module capture_raster_counter
    import capture_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_xStart,
    input  logic [COORD_W-1:0] i_xEnd,
    input  logic [COORD_W-1:0] i_yStart,
    input  logic [COORD_W-1:0] i_yEnd,
    input  logic               i_step,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_last
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_xStart;
    logic [COORD_W-1:0] r_xLast;
    logic [COORD_W-1:0] r_yLast;
    logic               w_rowEnd;

    // Inclusive last column/row are stored so the wrap test is a plain compare.
    assign w_rowEnd = (r_x == r_xLast);
    assign o_last   = w_rowEnd && (r_y == r_yLast);
    assign o_x      = r_x;
    assign o_y      = r_y;

    // Load snapshots the bounds; step walks the row and wraps to the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_xStart <= '0;
            r_xLast  <= '0;
            r_yLast  <= '0;
        end else if (i_load) begin
            r_x      <= i_xStart;
            r_y      <= i_yStart;
            r_xStart <= i_xStart;
            r_xLast  <= i_xEnd - 1'b1;
            r_yLast  <= i_yEnd - 1'b1;
        end else if (i_step) begin
            if (w_rowEnd) begin
                r_x <= r_xStart;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_engine.sv
// ---------------------------------------------------------------------------
// capture_engine
// Rectangular frame-buffer readback: on execute, walks the screen rectangle
// in raster order, reads each pixel through the SRAM controller read port and
// writes it to consecutive destination words.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   i_srcXStart/XEnd   : column range (start inclusive, end exclusive)
//   i_srcYStart/YEnd   : row range (start inclusive, end exclusive)
//   i_destAddrStart    : first destination word
//   i_execute          : level request, one capture per high period
//   o_status           : high while a capture is in FETCH/STORE
//   bus (master)       : fetch request/response and destination write port
// Optional feature: define CAPTURE_KEY_SKIP_EN to suppress writes of pixels
// equal to KeyColor (the destination address still advances).
// ---------------------------------------------------------------------------
module capture_engine
    import capture_pkg::*;
#(
    parameter int                 DestAddrWidth = 14,
    parameter logic [PIXEL_W-1:0] KeyColor      = 16'h0000
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COORD_W-1:0]       i_srcXStart,
    input  logic [COORD_W-1:0]       i_srcXEnd,
    input  logic [COORD_W-1:0]       i_srcYStart,
    input  logic [COORD_W-1:0]       i_srcYEnd,
    input  logic [DestAddrWidth-1:0] i_destAddrStart,
    input  logic                     i_execute,
    output logic                     o_status,
    capture_engine_if.master         bus
);

    capture_state_t           r_state;
    capture_state_t           w_nextState;
    logic                     r_status;
    logic                     r_fetchReq;
    logic                     r_destWrite;
    logic [DestAddrWidth-1:0] r_destAddr;
    logic [PIXEL_W-1:0]       r_destData;

    logic [COORD_W-1:0]       w_xEndClamped;
    logic [COORD_W-1:0]       w_yEndClamped;
    logic                     w_empty;
    logic                     w_start;
    logic                     w_capture;
    logic                     w_step;
    logic                     w_skip;
    logic                     w_last;
    logic [COORD_W-1:0]       w_x;
    logic [COORD_W-1:0]       w_y;

    // The region is clamped to the visible screen before deciding whether it
    // holds any pixels at all.
    assign w_xEndClamped = clampEnd(i_srcXEnd, SCREEN_W);
    assign w_yEndClamped = clampEnd(i_srcYEnd, SCREEN_H);
    assign w_empty       = (i_srcXStart >= w_xEndClamped) || (i_srcYStart >= w_yEndClamped);

`ifdef CAPTURE_KEY_SKIP_EN
    assign w_skip = (bus.fetchData == KeyColor);
`else
    assign w_skip = 1'b0;
`endif

    // Loading the counter is the moment the range inputs are latched; after
    // that, changes on the range inputs cannot affect the walk.
    capture_raster_counter u_raster (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_start),
        .i_xStart (i_srcXStart),
        .i_xEnd   (w_xEndClamped),
        .i_yStart (i_srcYStart),
        .i_yEnd   (w_yEndClamped),
        .i_step   (w_step),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_last   (w_last)
    );

    // Next-state logic. fetchValid only matters in FETCH; STORE always
    // advances the raster and either finishes or fetches the next pixel.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_execute) begin
                    if (w_empty) begin
                        w_nextState = DONE;
                    end else begin
                        w_start     = 1'b1;
                        w_nextState = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.fetchValid) begin
                    w_capture   = 1'b1;
                    w_nextState = STORE;
                end
            end
            STORE: begin
                w_step      = 1'b1;
                w_nextState = w_last ? DONE : FETCH;
            end
            DONE: begin
                if (!i_execute) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State plus every output is registered from the next-state decision, so
    // status/fetchReq/destWrite change on the same edge the state does and
    // never depend combinationally on inputs. destWrite is high only in the
    // single STORE cycle that follows a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_status    <= 1'b0;
            r_fetchReq  <= 1'b0;
            r_destWrite <= 1'b0;
            r_destAddr  <= '0;
            r_destData  <= '0;
        end else begin
            r_state     <= w_nextState;
            r_status    <= (w_nextState == FETCH) || (w_nextState == STORE);
            r_fetchReq  <= (w_nextState == FETCH);
            r_destWrite <= w_capture && !w_skip;
            if (w_start) begin
                r_destAddr <= i_destAddrStart;
            end else if (w_step) begin
                r_destAddr <= r_destAddr + 1'b1;
            end
            if (w_capture) begin
                r_destData <= bus.fetchData;
            end
        end
    end

    assign o_status      = r_status;
    assign bus.fetchReq  = r_fetchReq;
    assign bus.fetchX    = w_x;
    assign bus.fetchY    = w_y;
    assign bus.destAddr  = r_destAddr;
    assign bus.destData  = r_destData;
    assign bus.destWrite = r_destWrite;

endmodule

// File: doc/capture_engine.md
# capture_engine

Rectangular frame-buffer readback engine; the reader counterpart of the copy engine. On `execute`, it walks a screen rectangle in raster order, fetches each pixel from the SRAM frame buffer through the SRAM controller's read port, and writes the pixels sequentially into an on-chip destination memory. It sits between `sram_controller` (read side) and an on-chip RAM, and is used for saving the background under sprites and for snapshot capture.

## Interface
- `DestAddrWidth`, 14, width of the destination memory address.
- `KeyColor`, 16'h0000, pixel value suppressed when `CAPTURE_KEY_SKIP_EN` is defined.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `src_x_start`, `src_x_end` in 10: column range, start inclusive and end exclusive.
- `src_y_start`, `src_y_end` in 10: row range, start inclusive and end exclusive.
- `dest_addr_start` in DestAddrWidth: first destination word.
- `execute` in 1: level request to start a capture.
- `status` out 1: 1 while a capture is in progress.
- `fetch_x`, `fetch_y` out 10: coordinate of the pixel being requested.
- `fetch_req` out 1: read request to the SRAM controller.
- `fetch_valid` in 1: requested pixel data is on `fetch_data` this cycle.
- `fetch_data` in 16: pixel read from the frame buffer.
- `dest_addr` out DestAddrWidth, `dest_data` out 16, `dest_write` out 1: destination write port.

## Operation
- **States:** IDLE, FETCH, STORE, DONE.
- **Reset values:** state IDLE. `status`, `fetch_req` and `dest_write` are 0. `fetch_x`, `fetch_y`, `dest_addr` and `dest_data` are 0.
- **IDLE:**
  - When `execute`=1, latch all range inputs and `dest_addr_start`, then clamp `x_end` to 640 and `y_end` to 480.
  - If the clamped region is empty (x_start>=x_end or y_start>=y_end), go to DONE with no fetch.
  - Otherwise set x=x_start, y=y_start and go to FETCH.
- **FETCH:**
  - `fetch_req`=1, with `fetch_x`/`fetch_y` stable.
  - Stay in FETCH until `fetch_valid`=1, then capture `fetch_data` and go to STORE.
  - At most one request is outstanding.
- **STORE:**
  - Drive `dest_write`=1 for exactly one cycle with the current `dest_addr` and the captured data, then increment `dest_addr`.
  - Advance x. At x_end-1, set x=x_start and advance y.
  - After pixel (x_end-1, y_end-1), go to DONE. Otherwise go to FETCH.
- **DONE:** hold until `execute`=0, then go to IDLE. One capture is performed per `execute` high period.
- **status:** 1 in FETCH and STORE only.
- **Input stability:** range inputs are sampled only at start. Changes during a capture have no effect.
- **Address wrap:** `dest_addr` wraps modulo 2^DestAddrWidth with no error.
- **Ignored inputs:** `fetch_valid` outside FETCH is ignored.
- **Reset mid-capture:** state returns to IDLE the next cycle. `fetch_req` and `dest_write` drop and nothing further is written. A late `fetch_valid` is ignored.

## Timing
- `execute` seen at edge N: `fetch_req`=1 from edge N+1.
- `fetch_valid`=1 at edge M: `dest_write`=1 during cycle M+1.
- **Throughput:** 2 cycles/pixel minimum when `fetch_valid` returns in the same cycle as `fetch_req`.
- **Total cycles:** 2·W·H + controller wait cycles. `status` falls the cycle after the last `dest_write`.
- **Registered outputs:** all outputs are registered; none is combinational from inputs.

## Configuration
- **Macro:** `CAPTURE_KEY_SKIP_EN`.
- **Defined:** in STORE, if the captured pixel equals `KeyColor`, `dest_write` stays 0. `dest_addr` still increments, so the destination layout is preserved.
- **Undefined:** every pixel is written and `KeyColor` is unused.

## Structure
- **Package `capture_pkg`:**
  - state enum `capture_state_t`.
  - `SCREEN_W`=640, `SCREEN_H`=480.
  - `PIXEL_W`=16.
- **Sub-module `capture_raster_counter`:**
  - Holds the x/y counters.
  - Inputs: load (start/end values) and step.
  - Outputs: x, y, `last`.
  - Reusable by the copy engine.

## Test plan
- Region x 10..12, y 5..7, `dest_addr_start`=100, zero-wait controller:
  - fetches (10,5),(11,5),(10,6),(11,6).
  - writes addrs 100..103.
  - `status` high for 8 cycles.
- Random 0–5 cycle `fetch_valid` delay on a 4×3 region:
  - `fetch_x`/`fetch_y` stable while `fetch_req` is high.
  - 12 writes in order, data matching the model.
- Empty region (x_start=x_end=50):
  - no `fetch_req`, no `dest_write`.
  - DONE until `execute`=0.
- Clamp x 630..700, y 478..490: exactly 10×2=20 fetches, max `fetch_x`=639, max `fetch_y`=479.
- `reset` asserted while waiting in FETCH:
  - next cycle `fetch_req`=0.
  - subsequent `fetch_valid` produces no write.
  - new `execute` restarts from `dest_addr_start`.
- With `CAPTURE_KEY_SKIP_EN`, source pixels 0x0000,0x1234,0x0000,0xFFFF to `dest_addr_start`=0:
  - writes only addr 1 (0x1234) and addr 3 (0xFFFF).
